// File: rtl/cscv2_uart_pkg.sv
// Shared types and constants for the CSCv2 UART transmitter.
// The PARITY state is always declared; it is only reached when CSCV2_UART_PARITY_EN is defined.
package cscv2_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam int   DATA_BITS   = 8;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/cscv2_uart_fifo.sv
// Circular byte buffer with registered occupancy count.
// A push into a full buffer is accepted only when a pop frees a slot on the same edge.
module cscv2_uart_fifo
  import cscv2_uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = DATA_BITS,
  localparam int PTR_W     = $clog2(FIFO_DEPTH),
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_en_s, rd_en_s;

  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty   = (count_q == {CNT_W{1'b0}});
  assign wr_en_s = push & (~full | pop);
  assign rd_en_s = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Next pointer, count and storage values.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en_s) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_en_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_en_s, rd_en_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Buffer state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/cscv2_uart_tx.sv
// UART transmitter for the CSCv2 TX strobe: captures {aval,bval} on each falling strobe and sends 8N1.
// Define CSCV2_UART_PARITY_EN to insert an even-parity bit (8E1).
module cscv2_uart_tx
  import cscv2_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_n,
  input  logic [3:0] aval,
  input  logic [3:0] bval,
  output logic       serial_out,
  output logic       busy,
  output logic       overflow,
  output logic [4:0] fifo_count
);

  localparam int DIV_W = $clog2(CLKS_PER_BIT);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  uart_state_e          state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 tx_q;
  logic                 serial_out_q, serial_out_d;
  logic                 overflow_q, overflow_d;

  logic                 fall_s, pop_s, bit_end_s;
  logic                 full_s, empty_s;
  logic [DATA_BITS-1:0] rdata_s;
  logic [CNT_W-1:0]     count_s;

  assign fall_s    = tx_q & ~tx_n;
  assign bit_end_s = (div_q == DIV_W'(CLKS_PER_BIT - 1));

  cscv2_uart_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fall_s),
    .pop   (pop_s),
    .wdata ({aval, bval}),
    .rdata (rdata_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      div_q        <= {DIV_W{1'b0}};
      idx_q        <= 3'd0;
      sh_q         <= {DATA_BITS{1'b0}};
      tx_q         <= 1'b1;
      serial_out_q <= IDLE_LEVEL;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      idx_q        <= idx_d;
      sh_q         <= sh_d;
      tx_q         <= tx_n;
      serial_out_q <= serial_out_d;
      overflow_q   <= overflow_d;
    end
  end

  // Next state, bit divider and bit index.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    case (state_q)
      IDLE: begin
        if (!empty_s) begin
          state_d = START;
          div_d   = {DIV_W{1'b0}};
          sh_d    = rdata_s;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_d = DATA;
          div_d   = {DIV_W{1'b0}};
          idx_d   = 3'd0;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      DATA: begin
        if (bit_end_s) begin
          div_d = {DIV_W{1'b0}};
          if (idx_q == 3'(DATA_BITS - 1)) begin
`ifdef CSCV2_UART_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      PARITY: begin
`ifdef CSCV2_UART_PARITY_EN
        if (bit_end_s) begin
          state_d = STOP;
          div_d   = {DIV_W{1'b0}};
        end else begin
          div_d = div_q + DIV_W'(1);
        end
`else
        state_d = IDLE;
`endif
      end
      STOP: begin
        if (bit_end_s) begin
          state_d = IDLE;
          div_d   = {DIV_W{1'b0}};
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        div_d   = {DIV_W{1'b0}};
      end
    endcase
  end

  // Line level, FIFO pop and sticky overflow.
  always_comb begin
    pop_s      = (state_q == IDLE) & ~empty_s;
    overflow_d = overflow_q | (fall_s & full_s & ~pop_s);
    case (state_q)
      START:   serial_out_d = START_LEVEL;
      DATA:    serial_out_d = sh_q[idx_q];
`ifdef CSCV2_UART_PARITY_EN
      PARITY:  serial_out_d = even_parity(sh_q);
`endif
      default: serial_out_d = IDLE_LEVEL;
    endcase
  end

  assign serial_out = serial_out_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q != IDLE) | ~empty_s;
  assign fifo_count = 5'(count_s);

endmodule
